// File: rtl/osc_pkg.sv
// Shared definitions for the programmable oscillator: channel FSM encoding,
// default counter width and the phase-length clamp.
package osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } osc_state_e;

  localparam int OSC_CNT_W = 8;

  // A programmed length of 0 would make a phase vanish; treat it as 1 cycle.
  function automatic logic [31:0] clamp_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/osc_channel.sv
// One oscillator channel: shadow/active phase lengths, a down-counter per
// phase and registered OUT/TICK/RUN.
//
// state   | meaning
// IDLE    | stopped, OUT low, waiting for ena_i
// HIGH    | OUT high, cnt_q counts down the high phase
// LOW     | OUT low, cnt_q counts down the low phase; cnt_q==0 ends the period
module osc_channel
  import osc_pkg::*;
#(
  parameter int CNT_W  = OSC_CNT_W,
  parameter int DEF_HI = 4,
  parameter int DEF_LO = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             ena_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] cfg_hi_i,
  input  logic [CNT_W-1:0] cfg_lo_i,
  output logic             out_o,
  output logic             tick_o,
  output logic             run_o
);

  osc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_hi_q, sh_hi_d;
  logic [CNT_W-1:0] sh_lo_q, sh_lo_d;
  logic [CNT_W-1:0] act_lo_q, act_lo_d;
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sh_hi_q  <= CNT_W'(DEF_HI);
      sh_lo_q  <= CNT_W'(DEF_LO);
      act_lo_q <= CNT_W'(DEF_LO);
      out_q    <= 1'b0;
      tick_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_hi_q  <= sh_hi_d;
      sh_lo_q  <= sh_lo_d;
      act_lo_q <= act_lo_d;
      out_q    <= out_d;
      tick_q   <= tick_d;
      run_q    <= run_d;
    end
  end

  // The active high length is only needed at the moment the counter is
  // loaded, so only the low length is kept for the rest of the period.
  // Reloads read the pre-edge shadow, so a write on a boundary edge waits
  // one more period.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_lo_d = act_lo_q;
    out_d    = out_q;
    tick_d   = 1'b0;
    run_d    = run_q;
    sh_hi_d  = we_i ? CNT_W'(clamp_len(32'(cfg_hi_i))) : sh_hi_q;
    sh_lo_d  = we_i ? CNT_W'(clamp_len(32'(cfg_lo_i))) : sh_lo_q;

    case (state_q)
      ST_IDLE: begin
        if (ena_i) begin
          state_d  = ST_HIGH;
          cnt_d    = sh_hi_q - CNT_W'(1);
          act_lo_d = sh_lo_q;
          out_d    = 1'b1;
          tick_d   = 1'b1;
          run_d    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = act_lo_q - CNT_W'(1);
          out_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          if (ena_i) begin
            state_d  = ST_HIGH;
            cnt_d    = sh_hi_q - CNT_W'(1);
            act_lo_d = sh_lo_q;
            out_d    = 1'b1;
            tick_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            out_d   = 1'b0;
            run_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
        run_d   = 1'b0;
      end
    endcase
  end

  assign out_o  = out_q;
  assign tick_o = tick_q;
  assign run_o  = run_q;

endmodule

// File: rtl/prog_oscillator.sv
// Multi-channel programmable oscillator: one osc_channel per channel plus
// the decode of the shared configuration write port.
module prog_oscillator
  import osc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = OSC_CNT_W,
  parameter int DEF_HI = 4,
  parameter int DEF_LO = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [NUM_CH-1:0] ENA,
  input  logic              CFG_WE,
  input  logic [2:0]        CFG_SEL,
  input  logic [CNT_W-1:0]  CFG_HI,
  input  logic [CNT_W-1:0]  CFG_LO,
  output logic [NUM_CH-1:0] OUT,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] RUN
);

  logic [NUM_CH-1:0] we_ch;

  // Selects at or above NUM_CH match no channel and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign we_ch[i] = CFG_WE && (CFG_SEL == 3'(i));

    osc_channel #(
      .CNT_W (CNT_W),
      .DEF_HI(DEF_HI),
      .DEF_LO(DEF_LO)
    ) u_ch (
      .clk_i   (CLK),
      .rst_n_i (RSTN),
      .ena_i   (ENA[i]),
      .we_i    (we_ch[i]),
      .cfg_hi_i(CFG_HI),
      .cfg_lo_i(CFG_LO),
      .out_o   (OUT[i]),
      .tick_o  (TICK[i]),
      .run_o   (RUN[i])
    );
  end

endmodule
